sc_io_stream_dev: RTL and testbench
===================================

// Module: sc_io_stream_dev
// PURPOSE
//  SCOMP IO-bus peripheral; downstream of the WB-to-SCOMP translator. Decodes 4 regs at BASE_ADDR.
//  - RX FIFO, filled from a local valid/ready stream and drained by SCOMP reads.
//  - TX holding register, written by SCOMP and emitted on a local valid/ready stream.
//  - Free-running prescaled 16-bit timer; level IRQ on RX fill threshold.
//  Lives in the i_clk domain; samples IO-bus signals as plain synchronous inputs.
// PARAMETERS
//  BASE_ADDR  8'h10  IO address of reg 0; regs at BASE_ADDR+0..+3 (BASE_ADDR[1:0] must be 0)
//  DEPTH      16     RX FIFO entries, power of 2, 2..256
//  PRESCALE   50     i_clk cycles per timer increment, >=1
// PORTS
//  i_clk         in     1   system clock
//  i_reset       in     1   synchronous, active-high reset
//  i_sc_iocyc    in     1   IO cycle active
//  i_sc_iowr     in     1   1=write cycle, 0=read cycle
//  i_sc_ioaddr   in     8   IO address
//  io_sc_iodata  inout  16  IO data; driven only as defined under BEHAVIOUR
//  i_rx_valid    in     1   local producer word valid
//  i_rx_data     in     16  local producer word
//  o_rx_ready    out    1   RX FIFO can accept (= !full)
//  o_tx_valid    out    1   TX word pending
//  o_tx_data     out    16  TX word
//  i_tx_ready    in     1   local consumer accepts TX word
//  o_irq         out    1   RX level interrupt
// BEHAVIOUR
//  Reset: FIFO empty, count=0; o_tx_valid=0, o_tx_data=0; timer=0; prescale ctr=0; thresh=0;
//   sticky flags=0; o_irq=0; o_rx_ready=1; io_sc_iodata=Z. Reset mid-cycle aborts: no commit.
//  Hit: hit = i_sc_iocyc && i_sc_ioaddr[7:2]==BASE_ADDR[7:2]; reg = i_sc_ioaddr[1:0].
//  Capture: each i_clk with i_sc_iocyc=1, latch addr, iowr, iodata, hit into cyc_* regs.
//  Commit: on the cycle where cyc_d=1 && i_sc_iocyc=0 (iocyc falling edge), perform the latched
//   write or read side-effect exactly once. (Translator drops iocyc/iowr/ioaddr together, so
//   live signals are invalid at commit time.)
//  Read drive: io_sc_iodata = read mux while hit && !i_sc_iowr && !i_reset, else 16'hzzzz.
//   Combinational; stable for the whole cycle since state only changes on commit or local events.
//  Registers:
//   +0 DATA  R: FIFO head (16'h0 if empty); commit pops if non-empty, else sets UNF sticky.
//            W: if !o_tx_valid -> o_tx_data<=data, o_tx_valid<=1; else drop, set TXOVF sticky.
//   +1 STAT  R: {count[7:0], 3'b0, UNF, TXOVF, o_tx_valid, full, empty}. count is
//            $clog2(DEPTH+1) bits, zero-extended to 8.
//            W: W1C on bits[4:3] (UNF, TXOVF); other bits ignored.
//   +2 TIMER R: timer. W: timer<=data, prescale ctr<=0.
//   +3 THRSH R: {8'h0, thresh}. W: thresh<=data[7:0].
//  RX FIFO: push when i_rx_valid && o_rx_ready. Push+pop same cycle: count unchanged; pop returns
//   the old head. Pointers wrap mod DEPTH. full = count==DEPTH, empty = count==0.
//  TX: o_tx_valid && i_tx_ready clears o_tx_valid next cycle (o_tx_data held).
//   Write commit in the same cycle as a TX handshake is accepted (the slot frees this cycle).
//  Timer: prescale ctr counts 0..PRESCALE-1; at PRESCALE-1 timer+=1, wraps 16'hFFFF->0.
//   A bus write wins over an increment in the same cycle.
//  IRQ: o_irq registered = (thresh!=0) && (count >= thresh).
//  Non-hit cycles: captured but no commit side-effects; bus never driven.
// TESTING
//  1 Reset, then read STAT (BASE+1) -> 16'h0001; read TIMER twice >PRESCALE apart -> values differ.
//  2 Push 16'hA5A5, 16'h1234 via rx stream; read DATA twice -> A5A5 then 1234; STAT -> 0x0001.
//  3 Push DEPTH words -> o_rx_ready=0, STAT bit1=1, count=DEPTH; extra i_rx_valid is not accepted.
//  4 Write DATA 16'hBEEF with i_tx_ready=0 -> o_tx_valid=1, o_tx_data=BEEF; write 16'h1111 ->
//    dropped, STAT bit3=1; write STAT 0x0008 -> bit3 clears; i_tx_ready=1 -> o_tx_valid=0.
//  5 Write THRSH 3; push 3 words -> o_irq=1; one DATA read -> o_irq=0. Read empty DATA -> 0, UNF=1.
//  6 Assert i_reset between capture and iocyc fall of a DATA write -> no tx, all regs at reset values.
//    Access BASE+4 -> no side effects, io_sc_iodata stays Z.

Source files
------------

// File: rtl/sc_io_stream_dev_if.sv
//------------------------------------------------------------------------------
// Module : sc_io_stream_dev_if
// Brief  : SCOMP IO-bus control lines plus RX/TX local streams and IRQ.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sc_io_stream_dev_if;
  logic        sc_iocyc;
  logic        sc_iowr;
  logic [7:0]  sc_ioaddr;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        irq;

  modport master (
    output sc_iocyc, sc_iowr, sc_ioaddr, rx_valid, rx_data, tx_ready,
    input  rx_ready, tx_valid, tx_data, irq
  );

  modport slave (
    input  sc_iocyc, sc_iowr, sc_ioaddr, rx_valid, rx_data, tx_ready,
    output rx_ready, tx_valid, tx_data, irq
  );
endinterface

`default_nettype wire

// File: rtl/sc_io_stream_dev.sv
//------------------------------------------------------------------------------
// Module : sc_io_stream_dev
// Brief  : SCOMP IO peripheral with RX FIFO, TX holding register, timer, IRQ.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sc_io_stream_dev #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         DEPTH     = 16,
  parameter int         PRESCALE  = 50
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  sc_io_stream_dev_if.slave    bus,
  inout  wire  [15:0]          io_sc_iodata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [PW-1:0] C_PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] C_REG_DATA  = 2'd0;
  localparam logic [1:0] C_REG_STAT  = 2'd1;
  localparam logic [1:0] C_REG_TIMER = 2'd2;
  localparam logic [1:0] C_REG_THRSH = 2'd3;

  // Latched bus cycle
  logic        r_cyc_d;
  logic        r_cyc_hit;
  logic        r_cyc_wr;
  logic [1:0]  r_cyc_addr;
  logic [15:0] r_cyc_data;
  logic        r_cyc_abort;

  // FIFO
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Other state
  logic          r_tx_valid;
  logic [15:0]   r_tx_data;
  logic [15:0]   r_timer;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_thresh;
  logic          r_unf;
  logic          r_txovf;
  logic          r_irq;

  logic        w_hit;
  logic        w_commit;
  logic        w_cmt_wr;
  logic        w_cmt_rd;
  logic        w_wr_data;
  logic        w_wr_stat;
  logic        w_wr_timer;
  logic        w_wr_thrsh;
  logic        w_rd_data;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_tx_accept;
  logic        w_tx_hs;
  logic        w_tick;
  logic [7:0]  w_count8;
  logic [15:0] w_head;
  logic [15:0] w_rd_mux;

  assign w_hit   = bus.sc_iocyc && (bus.sc_ioaddr[7:2] == BASE_ADDR[7:2]);
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A reset inside a bus cycle suppresses the commit of that cycle
  assign w_commit   = r_cyc_d && !bus.sc_iocyc && r_cyc_hit && !r_cyc_abort;
  assign w_cmt_wr   = w_commit && r_cyc_wr;
  assign w_cmt_rd   = w_commit && !r_cyc_wr;
  assign w_wr_data  = w_cmt_wr && (r_cyc_addr == C_REG_DATA);
  assign w_wr_stat  = w_cmt_wr && (r_cyc_addr == C_REG_STAT);
  assign w_wr_timer = w_cmt_wr && (r_cyc_addr == C_REG_TIMER);
  assign w_wr_thrsh = w_cmt_wr && (r_cyc_addr == C_REG_THRSH);
  assign w_rd_data  = w_cmt_rd && (r_cyc_addr == C_REG_DATA);

  assign w_push      = bus.rx_valid && !w_full;
  assign w_pop       = w_rd_data && !w_empty;
  assign w_tx_hs     = r_tx_valid && bus.tx_ready;
  assign w_tx_accept = w_wr_data && (!r_tx_valid || bus.tx_ready);
  assign w_tick      = (r_pre == C_PRE_LAST);
  assign w_head      = w_empty ? 16'h0000 : r_mem[r_rd_ptr];

  generate
    if (CW >= 8) begin : g_cnt_trunc
      assign w_count8 = r_count[7:0];
    end else begin : g_cnt_ext
      assign w_count8 = {{(8-CW){1'b0}}, r_count};
    end
  endgenerate

  always_comb begin
    w_rd_mux = 16'h0000;
    case (bus.sc_ioaddr[1:0])
      C_REG_DATA:  w_rd_mux = w_head;
      C_REG_STAT:  w_rd_mux = {w_count8, 3'b000, r_unf, r_txovf, r_tx_valid, w_full, w_empty};
      C_REG_TIMER: w_rd_mux = r_timer;
      C_REG_THRSH: w_rd_mux = {8'h00, r_thresh};
      default:     w_rd_mux = 16'h0000;
    endcase
  end

  assign io_sc_iodata = (w_hit && !bus.sc_iowr && !i_reset) ? w_rd_mux : 16'hzzzz;

  assign bus.rx_ready = !w_full;
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;
  assign bus.irq      = r_irq;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cyc_d     <= 1'b0;
      r_cyc_hit   <= 1'b0;
      r_cyc_wr    <= 1'b0;
      r_cyc_addr  <= 2'd0;
      r_cyc_data  <= 16'h0000;
      r_cyc_abort <= 1'b1;
    end else begin
      r_cyc_d <= bus.sc_iocyc;
      if (bus.sc_iocyc) begin
        r_cyc_hit  <= w_hit;
        r_cyc_wr   <= bus.sc_iowr;
        r_cyc_addr <= bus.sc_ioaddr[1:0];
        r_cyc_data <= io_sc_iodata;
      end else begin
        r_cyc_abort <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) begin
      r_mem[r_wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 16'h0000;
      r_unf      <= 1'b0;
      r_txovf    <= 1'b0;
      r_thresh   <= 8'h00;
    end else begin
      if (w_tx_accept) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= r_cyc_data;
      end else if (w_tx_hs) begin
        r_tx_valid <= 1'b0;
      end
      if (w_wr_data && !w_tx_accept)            r_txovf <= 1'b1;
      else if (w_wr_stat && r_cyc_data[3])      r_txovf <= 1'b0;
      if (w_rd_data && w_empty)                 r_unf   <= 1'b1;
      else if (w_wr_stat && r_cyc_data[4])      r_unf   <= 1'b0;
      if (w_wr_thrsh) r_thresh <= r_cyc_data[7:0];
    end
  end

  // Bus write to TIMER takes priority over a prescaler increment
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timer <= 16'h0000;
      r_pre   <= '0;
    end else if (w_wr_timer) begin
      r_timer <= r_cyc_data;
      r_pre   <= '0;
    end else if (w_tick) begin
      r_timer <= r_timer + 16'd1;
      r_pre   <= '0;
    end else begin
      r_pre   <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_thresh != 8'h00) && (9'(r_count) >= 9'(r_thresh));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sc_io_stream_dev.sv
//------------------------------------------------------------------------------
// Module : tb_sc_io_stream_dev
// Brief  : Directed self-checking bench for sc_io_stream_dev.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sc_io_stream_dev;

  localparam logic [7:0] BASE     = 8'h10;
  localparam int         DEPTH    = 4;
  localparam int         PRESCALE = 5;

  logic        clk;
  logic        rst;
  logic        drv_en;
  logic [15:0] drv;
  wire  [15:0] sc_iodata;

  int n_chk;
  int n_err;

  sc_io_stream_dev_if bus ();

  assign sc_iodata = drv_en ? drv : 16'hzzzz;

  sc_io_stream_dev #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .PRESCALE  (PRESCALE)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .bus          (bus),
    .io_sc_iodata (sc_iodata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.sc_iocyc = 1'b1; bus.sc_iowr = 1'b1; bus.sc_ioaddr = addr;
    drv_en = 1'b1; drv = data;
    @(negedge clk);
    bus.sc_iocyc = 1'b0; bus.sc_iowr = 1'b0; bus.sc_ioaddr = 8'h00;
    drv_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [15:0] data);
    @(negedge clk);
    bus.sc_iocyc = 1'b1; bus.sc_iowr = 1'b0; bus.sc_ioaddr = addr;
    @(negedge clk);
    data = sc_iodata;
    bus.sc_iocyc = 1'b0; bus.sc_ioaddr = 8'h00;
    @(negedge clk);
  endtask

  task automatic rx_push(input logic [15:0] data);
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = data;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] t1;
    logic [15:0] t2;
    logic [15:0] words [4];
    n_chk = 0; n_err = 0;
    drv_en = 1'b0; drv = 16'h0000;
    bus.sc_iocyc = 1'b0; bus.sc_iowr = 1'b0; bus.sc_ioaddr = 8'h00;
    bus.rx_valid = 1'b0; bus.rx_data = 16'h0000; bus.tx_ready = 1'b0;
    words[0] = 16'h1001; words[1] = 16'h1002; words[2] = 16'h1003; words[3] = 16'h1004;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset state and free-running timer
    check("rst_rx_ready", {15'd0, bus.rx_ready}, 16'd1);
    check("rst_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
    check("rst_tx_data", bus.tx_data, 16'h0000);
    check("rst_irq", {15'd0, bus.irq}, 16'd0);
    bus_read(BASE + 8'd1, rd);
    check("rst_stat", rd, 16'h0001);
    bus_read(BASE + 8'd3, rd);
    check("rst_thrsh", rd, 16'h0000);
    bus_read(BASE + 8'd2, t1);
    repeat (PRESCALE + 2) @(negedge clk);
    bus_read(BASE + 8'd2, t2);
    check("timer_moves", {15'd0, (t1 != t2)}, 16'd1);
    bus_write(BASE + 8'd2, 16'hFFFF);
    repeat (6) @(negedge clk);
    bus_read(BASE + 8'd2, rd);
    check("timer_wrap", rd, 16'h0000);
    bus_write(BASE + 8'd2, 16'h0100);
    bus_read(BASE + 8'd2, rd);
    check("timer_write", rd, 16'h0100);

    // 2: basic FIFO order
    rx_push(16'hA5A5);
    rx_push(16'h1234);
    bus_read(BASE, rd);
    check("fifo_rd0", rd, 16'hA5A5);
    bus_read(BASE, rd);
    check("fifo_rd1", rd, 16'h1234);
    bus_read(BASE + 8'd1, rd);
    check("fifo_stat_empty", rd, 16'h0001);

    // 3: fill to DEPTH, extra word refused
    for (int i = 0; i < DEPTH; i++) rx_push(words[i]);
    check("full_rx_ready", {15'd0, bus.rx_ready}, 16'd0);
    bus_read(BASE + 8'd1, rd);
    check("full_stat", rd, 16'h0402);
    rx_push(16'h7777);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(BASE, rd);
      check("full_drain", rd, words[i]);
    end
    bus_read(BASE + 8'd1, rd);
    check("drain_stat", rd, 16'h0001);

    // 4: TX holding register and overflow sticky
    bus_write(BASE, 16'hBEEF);
    check("tx_valid_set", {15'd0, bus.tx_valid}, 16'd1);
    check("tx_data", bus.tx_data, 16'hBEEF);
    bus_write(BASE, 16'h1111);
    check("tx_data_kept", bus.tx_data, 16'hBEEF);
    bus_read(BASE + 8'd1, rd);
    check("txovf_stat", rd, 16'h000D);
    bus_write(BASE + 8'd1, 16'h0008);
    bus_read(BASE + 8'd1, rd);
    check("txovf_clr", rd, 16'h0005);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    check("tx_drained", {15'd0, bus.tx_valid}, 16'd0);
    check("tx_data_hold", bus.tx_data, 16'hBEEF);

    // 5: threshold interrupt and underflow
    bus_write(BASE + 8'd3, 16'hAB03);
    bus_read(BASE + 8'd3, rd);
    check("thrsh_rd", rd, 16'h0003);
    rx_push(16'h0001);
    rx_push(16'h0002);
    @(negedge clk);
    check("irq_below", {15'd0, bus.irq}, 16'd0);
    rx_push(16'h0003);
    @(negedge clk);
    check("irq_at", {15'd0, bus.irq}, 16'd1);
    bus_read(BASE, rd);
    @(negedge clk);
    check("irq_clr", {15'd0, bus.irq}, 16'd0);
    bus_read(BASE, rd);
    bus_read(BASE, rd);
    check("irq_last_word", rd, 16'h0003);
    bus_read(BASE, rd);
    check("unf_rd", rd, 16'h0000);
    bus_read(BASE + 8'd1, rd);
    check("unf_stat", rd, 16'h0011);

    // 6: reset inside a write cycle aborts it; non-hit access is inert
    @(negedge clk);
    bus.sc_iocyc = 1'b1; bus.sc_iowr = 1'b1; bus.sc_ioaddr = BASE;
    drv_en = 1'b1; drv = 16'hCAFE;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.sc_iocyc = 1'b0; bus.sc_iowr = 1'b0; bus.sc_ioaddr = 8'h00;
    drv_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
    check("abort_tx_data", bus.tx_data, 16'h0000);
    bus_read(BASE + 8'd1, rd);
    check("abort_stat", rd, 16'h0001);
    bus_read(BASE + 8'd3, rd);
    check("abort_thrsh", rd, 16'h0000);
    bus_write(BASE + 8'd4, 16'h5555);
    bus_write(BASE + 8'd7, 16'h0001);
    rx_push(16'h4242);
    bus_read(BASE + 8'd4, rd);
    check("nohit_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
    bus_read(BASE + 8'd3, rd);
    check("nohit_thrsh", rd, 16'h0000);
    bus_read(BASE + 8'd1, rd);
    check("nohit_stat", rd, 16'h0100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
